// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// dmem_arbiter
//   Shares one data-memory port between the MEM pipeline stage and an
//   external loader. Three-state FSM (IDLE/PIPE/LDR); the pipeline is
//   stalled until its access completes.
//   Optional feature macro: DMEM_ARB_RR_EN (round-robin tie breaking).
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DMWEM,
  input  logic        MtoRFselM,
  input  logic [31:0] ALU_outM,
  input  logic [31:0] DMinM,
  output logic        STALL,
  output logic [31:0] RDM,
  input  logic        LD_REQ,
  input  logic        LD_WE,
  input  logic [31:0] LD_ADDR,
  input  logic [31:0] LD_WDATA,
  output logic        LD_GNT,
  output logic        LD_DONE,
  output logic [31:0] LD_RDATA,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_RDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PIPE = 2'd1,
    LDR  = 2'd2
  } state_t;

  state_t      state;
  logic        preq;
  logic        lreq;
  logic        pipe_wins;
  logic        pipe_done;
  logic [31:0] rdm_hold;

  assign preq      = DMWEM | MtoRFselM;
  // The loader holds LD_REQ until it sees LD_DONE, so the request is ignored
  // during the pulse cycle to avoid re-granting the access it just finished.
  assign lreq      = LD_REQ & ~LD_DONE;
  assign pipe_done = (state == PIPE) & MEM_RDY;

`ifdef DMEM_ARB_RR_EN
  logic last_pipe;

  assign pipe_wins = preq & (~lreq | ~last_pipe);

  // Remember who won the most recent grant; reset favours the pipeline next.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_pipe <= 1'b0;
    end else if ((state == IDLE) && (preq || lreq)) begin
      last_pipe <= pipe_wins;
    end
  end
`else
  assign pipe_wins = preq;
`endif

  // Arbitration FSM with registered memory-side and loader-side outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= 32'h0;
      MEM_WDATA <= 32'h0;
      LD_GNT    <= 1'b0;
      LD_DONE   <= 1'b0;
      LD_RDATA  <= 32'h0;
      rdm_hold  <= 32'h0;
    end else begin
      LD_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (pipe_wins) begin
            state     <= PIPE;
            MEM_EN    <= 1'b1;
            MEM_WE    <= DMWEM;
            MEM_ADDR  <= ALU_outM;
            MEM_WDATA <= DMinM;
          end else if (lreq) begin
            state     <= LDR;
            MEM_EN    <= 1'b1;
            MEM_WE    <= LD_WE;
            MEM_ADDR  <= LD_ADDR;
            MEM_WDATA <= LD_WDATA;
            LD_GNT    <= 1'b1;
          end
        end
        PIPE: begin
          if (MEM_RDY) begin
            state  <= IDLE;
            MEM_EN <= 1'b0;
            MEM_WE <= 1'b0;
            if (!MEM_WE) rdm_hold <= MEM_RDATA;
          end
        end
        LDR: begin
          if (MEM_RDY) begin
            state   <= IDLE;
            MEM_EN  <= 1'b0;
            MEM_WE  <= 1'b0;
            LD_GNT  <= 1'b0;
            LD_DONE <= 1'b1;
            if (!MEM_WE) LD_RDATA <= MEM_RDATA;
          end
        end
        default: begin
          state  <= IDLE;
          MEM_EN <= 1'b0;
          MEM_WE <= 1'b0;
          LD_GNT <= 1'b0;
        end
      endcase
    end
  end

  // Load data bypasses straight through on the completing cycle, then holds.
  assign RDM   = (pipe_done && !MEM_WE) ? MEM_RDATA : rdm_hold;
  assign STALL = RST_N & preq & ~pipe_done;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench with a transaction-level reference model and a simple
//   word memory with programmable ready latency.
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLK, RST_N;
  logic        DMWEM, MtoRFselM;
  logic [31:0] ALU_outM, DMinM;
  logic        STALL;
  logic [31:0] RDM;
  logic        LD_REQ, LD_WE;
  logic [31:0] LD_ADDR, LD_WDATA;
  logic        LD_GNT, LD_DONE;
  logic [31:0] LD_RDATA;
  logic        MEM_EN, MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        MEM_RDY;

  dmem_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .DMWEM(DMWEM), .MtoRFselM(MtoRFselM), .ALU_outM(ALU_outM), .DMinM(DMinM),
    .STALL(STALL), .RDM(RDM),
    .LD_REQ(LD_REQ), .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_WDATA(LD_WDATA),
    .LD_GNT(LD_GNT), .LD_DONE(LD_DONE), .LD_RDATA(LD_RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_RDY(MEM_RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
  endtask

  // Memory: 64 words, ready after 'lat' cycles of an access.
  logic [31:0] mem [64];
  int lat = 0;
  int acc_cyc = 0;
  assign MEM_RDATA = mem[MEM_ADDR[7:2]];
  assign MEM_RDY   = MEM_EN && (acc_cyc >= lat);

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      mem[16] <= 32'hDEADBEEF;
    end else if (MEM_EN && MEM_WE && MEM_RDY) begin
      mem[MEM_ADDR[7:2]] <= MEM_WDATA;
    end
    if (MEM_EN && !MEM_RDY) acc_cyc <= acc_cyc + 1;
    else acc_cyc <= 0;
  end

  // Reference model: who owns the memory and what each party last received.
  int          owner = 0;      // 0 nobody, 1 pipeline, 2 loader
  int          m_last = 2;     // last grant owner
  bit          m_we = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdm = '0, m_ldr = '0;
  bit          mp, ml;
  int          win;

  always @(posedge CLK) begin
    if (!RST_N) begin
      owner = 0; m_last = 2; m_we = 1'b0; m_done = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdm = '0; m_ldr = '0;
    end else begin
      mp = DMWEM || MtoRFselM;
      ml = LD_REQ && !m_done;
      m_done = 1'b0;
      if (owner == 0) begin
        win = 0;
        if (mp && ml) win = (RR && m_last == 1) ? 2 : 1;
        else if (mp) win = 1;
        else if (ml) win = 2;
        if (win == 1) begin
          owner = 1; m_last = 1; m_we = DMWEM; m_addr = ALU_outM; m_wdata = DMinM;
        end else if (win == 2) begin
          owner = 2; m_last = 2; m_we = LD_WE; m_addr = LD_ADDR; m_wdata = LD_WDATA;
        end
      end else if (MEM_RDY) begin
        if (!m_we && owner == 1) m_rdm = mem[m_addr[7:2]];
        if (!m_we && owner == 2) m_ldr = mem[m_addr[7:2]];
        m_done = (owner == 2);
        owner  = 0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("stall", STALL, RST_N && (DMWEM || MtoRFselM) && !(owner == 1 && MEM_RDY));
      chk("mem_en", MEM_EN, owner != 0);
      chk("mem_we", MEM_WE, owner != 0 && m_we);
      chk("ld_gnt", LD_GNT, owner == 2);
      chk("ld_done", LD_DONE, m_done);
      chk("mem_addr", MEM_ADDR, m_addr);
      chk("mem_wdata", MEM_WDATA, m_wdata);
      chk("ld_rdata", LD_RDATA, m_ldr);
      chk("rdm", RDM, (owner == 1 && MEM_RDY && !m_we) ? mem[m_addr[7:2]] : m_rdm);
    end
  end

  // Grant order log and LD_DONE pulse counter.
  int  g [8];
  int  g_cnt = 0;
  int  done_cnt = 0;
  bit  prev_en = 1'b0;
  always @(negedge CLK) begin
    if (MEM_EN && !prev_en && g_cnt < 8) begin
      g[g_cnt] = LD_GNT ? 2 : 1;
      g_cnt++;
    end
    prev_en = MEM_EN;
    if (LD_DONE) done_cnt++;
  end

  task automatic pipe_op(input bit st, input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output int en_cyc, output logic [31:0] rdm_rel);
    bit ok;
    ok = 1'b0; stalls = 0; en_cyc = 0; rdm_rel = '0;
    DMWEM = st; MtoRFselM = !st; ALU_outM = a; DMinM = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK);
      if (MEM_EN) en_cyc++;
      if (STALL) stalls++;
      else begin ok = 1'b1; rdm_rel = RDM; end
      @(posedge CLK); #1;
    end
    DMWEM = 1'b0; MtoRFselM = 1'b0;
    if (!ok) chk("pipe_timeout", 32'd0, 32'd1);
  endtask

  task automatic ld_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int gnt_cyc);
    bit ok;
    ok = 1'b0; gnt_cyc = 0; rd = '0;
    LD_REQ = 1'b1; LD_WE = we; LD_ADDR = a; LD_WDATA = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK);
      if (LD_GNT) gnt_cyc++;
      if (LD_DONE) begin ok = 1'b1; rd = LD_RDATA; end
      @(posedge CLK); #1;
    end
    LD_REQ = 1'b0;
    if (!ok) chk("ld_timeout", 32'd0, 32'd1);
  endtask

  int          st_n, en_n, gn, d0;
  logic [31:0] rv;
  bit          fin;

  initial begin
    RST_N = 1'b0; DMWEM = 1'b0; MtoRFselM = 1'b0; ALU_outM = '0; DMinM = '0;
    LD_REQ = 1'b0; LD_WE = 1'b0; LD_ADDR = '0; LD_WDATA = '0;
    @(posedge CLK); #1;
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_mem_en", MEM_EN, 32'd0);
    chk("rst_ld_gnt", LD_GNT, 32'd0);
    chk("rst_ld_done", LD_DONE, 32'd0);
    chk("rst_mem_addr", MEM_ADDR, 32'h0);
    chk("rst_rdm", RDM, 32'h0);
    chk("rst_ld_rdata", LD_RDATA, 32'h0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Load with ready in the first access cycle
    lat = 0;
    pipe_op(1'b0, 32'h40, 32'h0, st_n, en_n, rv);
    chk("load_stalls", st_n, 32'd1);
    chk("load_en_cycles", en_n, 32'd1);
    chk("load_rdm", rv, 32'hDEADBEEF);

    // Store completing on the third access cycle
    lat = 2;
    pipe_op(1'b1, 32'h10, 32'h12345678, st_n, en_n, rv);
    chk("store_stalls", st_n, 32'd3);
    chk("store_mem", mem[4], 32'h12345678);

    // Loader write then read back
    lat = 1;
    d0 = done_cnt;
    ld_op(1'b1, 32'h80, 32'hA5A5A5A5, rv, gn);
    chk("ldw_gnt_cycles", gn, 32'd2);
    ld_op(1'b0, 32'h80, 32'h0, rv, gn);
    chk("ldr_gnt_cycles", gn, 32'd2);
    chk("ldr_rdata", rv, 32'hA5A5A5A5);
    chk("ld_done_pulses", done_cnt - d0, 32'd2);
    @(posedge CLK); #1;
    chk("ld_rdata_held", LD_RDATA, 32'hA5A5A5A5);

    // Persistent tie from reset
    RST_N = 1'b0; lat = 0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    g_cnt = 0;
    MtoRFselM = 1'b1; ALU_outM = 32'h44;
    LD_REQ = 1'b1; LD_WE = 1'b0; LD_ADDR = 32'h84;
    fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge CLK);
      if (g_cnt >= 3 && !STALL) fin = 1'b1;
      @(posedge CLK); #1;
    end
    MtoRFselM = 1'b0;
    chk("tie_grant_order", g[0] * 100 + g[1] * 10 + g[2], RR ? 32'd121 : 32'd111);
    fin = 1'b0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge CLK);
      if (LD_DONE) fin = 1'b1;
      @(posedge CLK); #1;
    end
    LD_REQ = 1'b0;
    chk("tie_loader_served", fin, 32'd1);

    // Reset during a stalled loader access
    lat = 1000;
    LD_REQ = 1'b1; LD_WE = 1'b0; LD_ADDR = 32'h88;
    fin = 1'b0;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge CLK);
      if (LD_GNT) fin = 1'b1;
      @(posedge CLK); #1;
    end
    chk("rst_ldr_granted", fin, 32'd1);
    repeat (2) @(posedge CLK);
    #1;
    d0 = done_cnt;
    RST_N = 1'b0; LD_REQ = 1'b0; MtoRFselM = 1'b1; ALU_outM = 32'h40;
    @(negedge CLK);
    chk("stall_in_reset", STALL, 32'd0);
    @(negedge CLK);
    chk("rst_abort_mem_en", MEM_EN, 32'd0);
    chk("rst_abort_ld_gnt", LD_GNT, 32'd0);
    @(posedge CLK); #1;
    MtoRFselM = 1'b0; RST_N = 1'b1; lat = 0;
    repeat (8) @(negedge CLK);
    chk("rst_abort_no_done", done_cnt - d0, 32'd0);

    @(posedge CLK); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Clock and reset SHALL be one clock, CLK; reset is synchronous and active-low, RST_N.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  synchronous active-low reset.
REQ-004 DMWEM  input  1  MEM-stage store request.
REQ-005 MtoRFselM  input  1  MEM-stage load request.
REQ-006 ALU_outM  input  32  MEM-stage byte address.
REQ-007 DMinM  input  32  MEM-stage store data.
REQ-008 STALL  output  1  freeze PC, IF/ID, ID/EX and EX/MEM registers.
REQ-009 RDM  output  32  load data to the MEM/WB register.
REQ-010 LD_REQ  input  1  loader request, held until LD_DONE.
REQ-011 LD_WE  input  1  loader write (1) or read (0).
REQ-012 LD_ADDR, LD_WDATA  input  32 each  loader address and write data.
REQ-013 LD_GNT  output  1  loader owns the memory.
REQ-014 LD_DONE  output  1  one-cycle loader completion pulse.
REQ-015 LD_RDATA  output  32  loader read data, valid with LD_DONE and held after it.
REQ-016 MEM_EN, MEM_WE  output  1 each  memory access enable and write enable.
REQ-017 MEM_ADDR, MEM_WDATA  output  32 each  memory address and write data.
REQ-018 MEM_RDATA  input  32  memory read data.
REQ-019 MEM_RDY  input  1  access complete; sampled only while MEM_EN=1.

Function
REQ-020 Pipeline request (preq) SHALL be DMWEM|MtoRFselM; DMWEM=MtoRFselM=1 SHALL be treated as a store.
REQ-021 The FSM SHALL have three states: IDLE, PIPE and LDR.
REQ-022 In IDLE, the FSM SHALL move to PIPE or LDR on a request, selected per REQ-029/030, latching the winner's address, data and write flag into MEM_ADDR, MEM_WDATA and MEM_WE.
REQ-023 In PIPE and LDR, MEM_EN SHALL be 1 and MEM_ADDR, MEM_WDATA and MEM_WE SHALL be stable; in IDLE, MEM_EN and MEM_WE SHALL be 0.
REQ-024 On PIPE with MEM_RDY=1, the FSM SHALL return to IDLE, and for loads RDM SHALL equal MEM_RDATA combinationally that cycle and hold that value thereafter.
REQ-025 STALL SHALL equal preq & ~(state==PIPE & MEM_RDY), giving a minimum of 1 stall cycle per access; pipeline inputs are held stable while STALL=1.
REQ-026 On LDR with MEM_RDY=1, the FSM SHALL return to IDLE, pulse LD_DONE for the next cycle, and register LD_RDATA from MEM_RDATA on reads.
REQ-027 LD_GNT SHALL be 1 exactly while in LDR.
REQ-028 An LD_REQ drop mid-access SHALL NOT abort the access; LD_DONE SHALL still pulse.
REQ-029 With no configuration macro, priority SHALL be fixed: the pipeline wins any tie, and the loader may starve.
REQ-030 The FSM SHALL return to IDLE for at least 1 cycle between accesses, with no back-to-back grant.
REQ-031 An unbounded MEM_RDY wait SHALL hold the current state, with no timeout.

Reset
REQ-032 With RST_N=0 at a rising edge, the FSM SHALL go to IDLE; MEM_EN, MEM_WE, LD_GNT and LD_DONE SHALL be 0; MEM_ADDR, MEM_WDATA, RDM hold and LD_RDATA SHALL be 0x00000000; last-grant SHALL be loader.
REQ-033 STALL SHALL be 0 while RST_N=0.
REQ-034 Reset mid-access SHALL abandon the access with no LD_DONE, and MEM_EN SHALL be 0 from the next cycle.

Configuration
REQ-035 With DMEM_ARB_RR_EN defined, ties SHALL be resolved round-robin against the last grant: after a PIPE access the loader wins the next tie, and after an LDR access the pipeline wins.
REQ-036 Without DMEM_ARB_RR_EN, REQ-029 SHALL apply and no last-grant register SHALL be synthesized.

Verification
REQ-037 Load with MEM_RDY tied 1: MtoRFselM=1, ALU_outM=0x40, MEM_RDATA=0xDEADBEEF -> MEM_EN for 1 cycle, STALL=1 for 1 cycle, RDM=0xDEADBEEF on the release cycle.
REQ-038 Store with MEM_RDY after 3 cycles in PIPE: DMWEM=1, addr 0x10, data 0x12345678 -> MEM_WE=1, MEM_ADDR=0x10, MEM_WDATA=0x12345678, STALL=1 for 3 cycles.
REQ-039 Loader write then read of 0x80 with data 0xA5A5A5A5 -> LD_GNT during each access, two LD_DONE pulses, LD_RDATA=0xA5A5A5A5 after the second.
REQ-040 LD_REQ and preq asserted together from reset, 3 consecutive ties -> grant order P,P,P without the macro and P,L,P with DMEM_ARB_RR_EN.
REQ-041 RST_N=0 during LDR with MEM_RDY=0 -> next cycle MEM_EN=0, LD_GNT=0, and no LD_DONE pulse ever for that access.
